// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 fetch/decode/execute sequencer. Owns PC, IR, MDR and NZP and drives one shared memory port.
// Outputs are registered from the next state, so every strobe lines up with the state it belongs to.
module lc3_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  input  logic [15:0] i_result,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_ir,
  output logic [15:0] o_mdr,
  output logic        o_reg_we,
  output logic        o_reg_sel,
  output logic [1:0]  o_alu_op,
  output logic [15:0] o_pc,
  output logic [2:0]  o_nzp,
  output logic        o_illegal,
  output logic        o_halted,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state;
  state_t      state_n;
  logic [15:0] pc_n;
  logic [15:0] ea;
  logic [3:0]  op;
  logic        is_alu;

  function automatic logic [2:0] flags(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  function automatic logic legal_op(input logic [3:0] opc);
    case (opc)
      OP_BR, OP_ADD, OP_LD, OP_ST, OP_AND, OP_NOT, OP_HALT: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] opc);
    case (opc)
      OP_ADD:  return 2'b00;
      OP_AND:  return 2'b01;
      OP_NOT:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  assign op      = o_ir[15:12];
  assign is_alu  = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  // pc has already been incremented by the time ir is decoded
  assign ea      = o_pc + {{7{o_ir[8]}}, o_ir[8:0]};
  assign o_state = state;

  always_comb begin
    state_n = state;
    pc_n    = o_pc;
    case (state)
      S_IDLE:  if (i_start) state_n = S_FETCH;
      S_FETCH: begin
        if (i_mem_ready) begin
          state_n = S_DECODE;
          pc_n    = o_pc + 16'd1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT, OP_BR: state_n = S_EXEC;
          OP_LD, OP_ST:                  state_n = S_MEM;
          OP_HALT:                       state_n = S_HALT;
          default:                       state_n = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_n = S_FETCH;
        if ((op == OP_BR) && ((o_ir[11:9] & o_nzp) != 3'b000)) pc_n = ea;
      end
      S_MEM:   if (i_mem_ready) state_n = (op == OP_LD) ? S_WB : S_FETCH;
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_pc       <= RESET_PC;
      o_ir       <= 16'h0;
      o_mdr      <= 16'h0;
      o_nzp      <= 3'b010;
      o_mem_req  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= RESET_PC;
      o_reg_we   <= 1'b0;
      o_reg_sel  <= 1'b0;
      o_alu_op   <= 2'b11;
      o_illegal  <= 1'b0;
      o_halted   <= 1'b0;
    end else begin
      state <= state_n;
      o_pc  <= pc_n;
      if (state == S_FETCH && i_mem_ready) o_ir <= i_mem_rdata;
      if (state == S_MEM && i_mem_ready && op == OP_LD) o_mdr <= i_mem_rdata;
      if ((state == S_EXEC && is_alu) || state == S_WB) o_nzp <= flags(i_result);

      // Memory port: address and direction are set on entry and stay put until ready
      o_mem_req  <= (state_n == S_FETCH) || (state_n == S_MEM);
      o_mem_we   <= (state_n == S_MEM) && (op == OP_ST);
      o_mem_addr <= (state_n == S_MEM) ? ea : pc_n;

      o_reg_we   <= ((state_n == S_EXEC) && is_alu) || (state_n == S_WB);
      o_reg_sel  <= (state_n == S_WB);
      o_alu_op   <= (state_n == S_EXEC) ? alu_sel(op) : 2'b11;
      o_illegal  <= (state == S_FETCH) && i_mem_ready && !legal_op(i_mem_rdata[15:12]);
      o_halted   <= (state_n == S_HALT);
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm; a second instance with RESET_PC=FFFF covers PC wrap.
module tb_lc3_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n, start, start2, ready;
  logic [15:0] rdata, result;

  logic        req, we, reg_we, reg_sel, illegal, halted;
  logic [15:0] addr, ir, mdr, pc;
  logic [1:0]  alu_op;
  logic [2:0]  nzp, state;

  logic        req2, we2, reg_we2, reg_sel2, illegal2, halted2;
  logic [15:0] addr2, ir2, mdr2, pc2;
  logic [1:0]  alu_op2;
  logic [2:0]  nzp2, state2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc3_control_fsm dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_rdata(rdata),
    .i_mem_ready(ready), .i_result(result), .o_mem_req(req), .o_mem_we(we),
    .o_mem_addr(addr), .o_ir(ir), .o_mdr(mdr), .o_reg_we(reg_we),
    .o_reg_sel(reg_sel), .o_alu_op(alu_op), .o_pc(pc), .o_nzp(nzp),
    .o_illegal(illegal), .o_halted(halted), .o_state(state)
  );

  lc3_control_fsm #(.RESET_PC(16'hFFFF)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_start(start2), .i_mem_rdata(rdata),
    .i_mem_ready(ready), .i_result(result), .o_mem_req(req2), .o_mem_we(we2),
    .o_mem_addr(addr2), .o_ir(ir2), .o_mdr(mdr2), .o_reg_we(reg_we2),
    .o_reg_sel(reg_sel2), .o_alu_op(alu_op2), .o_pc(pc2), .o_nzp(nzp2),
    .o_illegal(illegal2), .o_halted(halted2), .o_state(state2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Completes a zero-wait fetch; leaves the DUT in DECODE
  task automatic fetch(input logic [15:0] instr);
    rdata = instr;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    ready = 1'b0; rdata = 16'h0; result = 16'h0;
    repeat (2) tick();

    // Reset state
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 16'h3000);
    check("rst_ir", ir, 16'h0);
    check("rst_mdr", mdr, 16'h0);
    check("rst_nzp", nzp, 3'b010);
    check("rst_req", req, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst2_pc", pc2, 16'hFFFF);

    // 1: ADD R1,R1,#1 with result 5
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_fetch_state", state, 3'd1);
    check("t1_fetch_req", req, 1'b1);
    check("t1_fetch_addr", addr, 16'h3000);
    check("t1_fetch_we", we, 1'b0);
    fetch(16'h1261);
    check("t1_dec_state", state, 3'd2);
    check("t1_ir", ir, 16'h1261);
    check("t1_pc", pc, 16'h3001);
    check("t1_dec_req", req, 1'b0);
    tick();
    check("t1_exec_state", state, 3'd3);
    check("t1_exec_reg_we", reg_we, 1'b1);
    check("t1_exec_reg_sel", reg_sel, 1'b0);
    check("t1_exec_alu_op", alu_op, 2'b00);
    result = 16'd5;
    tick();
    check("t1_next_state", state, 3'd1);
    check("t1_reg_we_drop", reg_we, 1'b0);
    check("t1_nzp", nzp, 3'b001);
    check("t1_next_addr", addr, 16'h3001);

    // 2: BRz +4 not taken with nzp=001, then taken with nzp=010
    fetch(16'h0404);
    tick();
    check("t2_br_reg_we", reg_we, 1'b0);
    tick();
    check("t2_nt_pc", pc, 16'h3002);
    check("t2_nt_nzp", nzp, 3'b001);
    fetch(16'h1261);
    tick();
    result = 16'h0000;
    tick();
    check("t2_zero_nzp", nzp, 3'b010);
    fetch(16'h0404);
    tick();
    tick();
    check("t2_tk_pc", pc, 16'h3008);
    check("t2_tk_addr", addr, 16'h3008);
    check("t2_tk_nzp", nzp, 3'b010);
    fetch(16'h5262);
    tick();
    check("t2_and_alu_op", alu_op, 2'b01);
    result = 16'h8000;
    tick();
    check("t2_neg_nzp", nzp, 3'b100);
    fetch(16'h927F);
    tick();
    check("t2_not_alu_op", alu_op, 2'b10);
    result = 16'h0001;
    tick();
    check("t2_pos_nzp", nzp, 3'b001);

    // 3: LD R2,#-1 with three wait cycles in MEM
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(16'h25FF);
    check("t3_pc", pc, 16'h3001);
    tick();
    check("t3_mem_state", state, 3'd4);
    check("t3_mem_req0", req, 1'b1);
    check("t3_mem_addr0", addr, 16'h3000);
    check("t3_mem_we0", we, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_mem_req_wait", req, 1'b1);
      check("t3_mem_addr_wait", addr, 16'h3000);
      check("t3_mem_state_wait", state, 3'd4);
    end
    rdata = 16'hBEEF;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_wb_state", state, 3'd5);
    check("t3_mdr", mdr, 16'hBEEF);
    check("t3_wb_req", req, 1'b0);
    check("t3_wb_reg_we", reg_we, 1'b1);
    check("t3_wb_reg_sel", reg_sel, 1'b1);
    result = 16'h8001;
    tick();
    check("t3_after_state", state, 3'd1);
    check("t3_after_nzp", nzp, 3'b100);
    check("t3_after_reg_we", reg_we, 1'b0);
    check("t3_after_addr", addr, 16'h3001);

    // 6: asynchronous reset while a fetch request is outstanding
    check("t6_req_before", req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_req", req, 1'b0);
    check("t6_state", state, 3'd0);
    check("t6_pc", pc, 16'h3000);
    tick();
    rst_n = 1'b1;

    // 5: illegal opcode 1101 is a NOP, then HALT absorbs
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(16'hD000);
    check("t5_illegal", illegal, 1'b1);
    check("t5_ill_state", state, 3'd2);
    tick();
    check("t5_illegal_drop", illegal, 1'b0);
    check("t5_ill_next_state", state, 3'd1);
    check("t5_ill_pc", pc, 16'h3001);
    fetch(16'hF025);
    check("t5_halt_no_ill", illegal, 1'b0);
    tick();
    check("t5_halted", halted, 1'b1);
    check("t5_halt_state", state, 3'd6);
    start = 1'b1;
    rdata = 16'h1234;
    ready = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    ready = 1'b0;
    tick();
    check("t5_halt_stays", state, 3'd6);
    check("t5_halt_ir", ir, 16'hF025);
    check("t5_halt_req", req, 1'b0);
    check("t5_halted_hold", halted, 1'b1);

    // 4: ST at pc=FFFF wraps pc to 0000 and EA is formed from 0000
    rst2_n = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t4_fetch_addr", addr2, 16'hFFFF);
    fetch(16'h3005);
    check("t4_pc_wrap", pc2, 16'h0000);
    tick();
    check("t4_mem_state", state2, 3'd4);
    check("t4_mem_req", req2, 1'b1);
    check("t4_mem_we", we2, 1'b1);
    check("t4_mem_addr", addr2, 16'h0005);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t4_after_state", state2, 3'd1);
    check("t4_after_we", we2, 1'b0);
    check("t4_after_addr", addr2, 16'h0000);
    check("t4_after_reg_we", reg_we2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
